// File: rtl/dm_store_responder_pkg.sv
// rtl/dm_store_responder_pkg.sv - shared constants and byte-enable encodings for the data-memory responder
package dm_store_responder_pkg;

    localparam int DM_DEPTH = 3072;
    localparam int DM_IDX_W = 12;
    localparam int DM_LANES = 4;

    typedef logic [DM_LANES-1:0] byte_en_t;

    localparam byte_en_t BE_NONE    = 4'b0000;
    localparam byte_en_t BE_WORD    = 4'b1111;
    localparam byte_en_t BE_HALF_LO = 4'b0011;
    localparam byte_en_t BE_HALF_HI = 4'b1100;
    localparam byte_en_t BE_B0      = 4'b0001;
    localparam byte_en_t BE_B1      = 4'b0010;
    localparam byte_en_t BE_B2      = 4'b0100;
    localparam byte_en_t BE_B3      = 4'b1000;

    function automatic logic is_store(input byte_en_t be);
        return be != BE_NONE;
    endfunction

endpackage

// File: rtl/dm_store_responder_if.sv
// rtl/dm_store_responder_if.sv - MEM-stage load/store bus plus store trace and fault reporting
interface dm_store_responder_if;
    import dm_store_responder_pkg::*;

    logic [31:0] addr;
    byte_en_t    byte_en;
    logic [31:0] wdata;
    logic [31:0] inst_addr;
    logic [31:0] rdata;
    logic        log_valid;
    logic [31:0] log_pc;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] store_count;

    modport master (
        output addr, byte_en, wdata, inst_addr,
        input  rdata, log_valid, log_pc, log_addr, log_data, fault, fault_addr, store_count
    );

    modport slave (
        input  addr, byte_en, wdata, inst_addr,
        output rdata, log_valid, log_pc, log_addr, log_data, fault, fault_addr, store_count
    );

endinterface

// File: rtl/dm_lane_merge.sv
// rtl/dm_lane_merge.sv - replaces the enabled byte lanes of a word with lane-aligned write data
module dm_lane_merge
    import dm_store_responder_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  byte_en_t    byte_en,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < DM_LANES; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_store_responder.sv
// rtl/dm_store_responder.sv - data-memory responder with one-entry posted write buffer and load bypass
module dm_store_responder
    import dm_store_responder_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int IDX_W = DM_IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    dm_store_responder_if.slave   bus
);

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    logic [31:0]      mem_q [0:DEPTH-1];

    logic             buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0] buf_idx_q,   buf_idx_d;
    logic [31:0]      buf_word_q,  buf_word_d;
    logic             log_valid_q, log_valid_d;
    logic [31:0]      log_pc_q,    log_pc_d;
    logic [31:0]      log_addr_q,  log_addr_d;
    logic             fault_q,     fault_d;
    logic [31:0]      fault_addr_q, fault_addr_d;
    logic [31:0]      store_count_q, store_count_d;

    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             store_acc;
    logic [31:0]      rd_word;
    logic [31:0]      merged;

    assign idx       = bus.addr[IDX_W+1:2];
    assign in_range  = bus.addr[31:2] < DEPTH_W;
    assign store_acc = in_range && is_store(bus.byte_en);

    // The buffer shadows the array until its commit edge, so reads must see it first.
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            if (buf_valid_q && (buf_idx_q == idx)) begin
                rd_word = buf_word_q;
            end else begin
                rd_word = mem_q[idx];
            end
        end
    end

    // Merging on top of the bypassed word lets back-to-back stores to one word coalesce.
    dm_lane_merge u_lane_merge (
        .old_word (rd_word),
        .wdata    (bus.wdata),
        .byte_en  (bus.byte_en),
        .merged   (merged)
    );

    always_comb begin
        buf_valid_d   = store_acc;
        buf_idx_d     = buf_idx_q;
        buf_word_d    = buf_word_q;
        log_valid_d   = store_acc;
        log_pc_d      = log_pc_q;
        log_addr_d    = log_addr_q;
        store_count_d = store_count_q;
        fault_d       = fault_q;
        fault_addr_d  = fault_addr_q;

        if (store_acc) begin
            buf_idx_d     = idx;
            buf_word_d    = merged;
            log_pc_d      = bus.inst_addr;
            log_addr_d    = {bus.addr[31:2], 2'b00};
            store_count_d = store_count_q + 32'd1;
        end

        if (!in_range) begin
            fault_d = 1'b1;
            if (!fault_q) begin
                fault_addr_d = bus.addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q   <= 1'b0;
            buf_idx_q     <= '0;
            buf_word_q    <= '0;
            log_valid_q   <= 1'b0;
            log_pc_q      <= '0;
            log_addr_q    <= '0;
            fault_q       <= 1'b0;
            fault_addr_q  <= '0;
            store_count_q <= '0;
        end else begin
            buf_valid_q   <= buf_valid_d;
            buf_idx_q     <= buf_idx_d;
            buf_word_q    <= buf_word_d;
            log_valid_q   <= log_valid_d;
            log_pc_q      <= log_pc_d;
            log_addr_q    <= log_addr_d;
            fault_q       <= fault_d;
            fault_addr_q  <= fault_addr_d;
            store_count_q <= store_count_d;
        end
    end

    // A buffer still pending at reset is dropped rather than committed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (buf_valid_q) begin
            mem_q[buf_idx_q] <= buf_word_q;
        end
    end

    assign bus.rdata       = rd_word;
    assign bus.log_valid   = log_valid_q;
    assign bus.log_pc      = log_pc_q;
    assign bus.log_addr    = log_addr_q;
    assign bus.log_data    = buf_word_q;
    assign bus.fault       = fault_q;
    assign bus.fault_addr  = fault_addr_q;
    assign bus.store_count = store_count_q;

endmodule

// File: tb/tb_dm_store_responder.sv
// tb/tb_dm_store_responder.sv - vector table, reset corner cases and randomized byte-memory model for dm_store_responder
module tb_dm_store_responder;

    localparam int DEPTH = 3072;

    logic clk;
    logic reset;

    dm_store_responder_if bus ();

    dm_store_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a plain byte-addressed memory plus the last accepted store.
    logic [7:0]  mb [0:4*DEPTH-1];
    logic        m_lv;
    logic [31:0] m_pc, m_laddr, m_ldata, m_faddr, m_cnt;
    logic        m_fault;

    logic [31:0] s_rdata, s_pc, s_laddr, s_ldata, s_faddr, s_cnt;
    logic        s_lv, s_fault;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] exp_rdata;
        logic        exp_lv;
        logic [31:0] exp_pc;
        logic [31:0] exp_laddr;
        logic [31:0] exp_ldata;
        logic        exp_fault;
        logic [31:0] exp_faddr;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_in_range(input logic [31:0] a);
        return a[31:2] < 30'(DEPTH);
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int w;
        if (!m_in_range(a)) return 32'h0;
        w = int'(a[31:2]);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
        m_lv = 0; m_pc = 0; m_laddr = 0; m_ldata = 0;
        m_fault = 0; m_faddr = 0; m_cnt = 0;
    endtask

    task automatic model_update(input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] pc);
        int w;
        m_lv = 1'b0;
        if (!m_in_range(a)) begin
            if (!m_fault) m_faddr = a;
            m_fault = 1'b1;
        end else if (be != 4'b0000) begin
            w = int'(a[31:2]);
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mb[4*w+k] = wd[8*k +: 8];
            end
            m_lv    = 1'b1;
            m_pc    = pc;
            m_laddr = {a[31:2], 2'b00};
            m_ldata = m_word(a);
            m_cnt   = m_cnt + 32'd1;
        end
    endtask

    // Applies inputs for one cycle: rdata sampled before the edge, registered outputs after it.
    task automatic drive(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] pc, input logic rst);
        bus.addr      = a;
        bus.byte_en   = be;
        bus.wdata     = wd;
        bus.inst_addr = pc;
        reset         = rst;
        #1;
        s_rdata = bus.rdata;
        @(posedge clk);
        #1;
        s_lv    = bus.log_valid;
        s_pc    = bus.log_pc;
        s_laddr = bus.log_addr;
        s_ldata = bus.log_data;
        s_fault = bus.fault;
        s_faddr = bus.fault_addr;
        s_cnt   = bus.store_count;
    endtask

    task automatic chk_regs_vs_model(input string tag);
        chk({tag, ".log_valid"},   32'(s_lv),    32'(m_lv));
        chk({tag, ".log_pc"},      s_pc,         m_pc);
        chk({tag, ".log_addr"},    s_laddr,      m_laddr);
        chk({tag, ".log_data"},    s_ldata,      m_ldata);
        chk({tag, ".fault"},       32'(s_fault), 32'(m_fault));
        chk({tag, ".fault_addr"},  s_faddr,      m_faddr);
        chk({tag, ".store_count"}, s_cnt,        m_cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, wd, pc, exp_r;
        logic [3:0]  be;
        int          r;

        //             addr          be       wdata          pc            rdata         lv  log_pc        log_addr      log_data      f  fault_addr    cnt
        vec[0]  = '{32'h0000_0010, 4'b0000, 32'h0,         32'h0,        32'h0,         0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        32'd0};
        vec[1]  = '{32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0000_3000, 32'h0,        1, 32'h3000,     32'h10,       32'h1234_5678, 0, 32'h0,       32'd1};
        vec[2]  = '{32'h0000_0010, 4'b0000, 32'h0,         32'h0,        32'h1234_5678, 0, 32'h3000,     32'h10,       32'h1234_5678, 0, 32'h0,       32'd1};
        vec[3]  = '{32'h0000_0010, 4'b0000, 32'h0,         32'h0,        32'h1234_5678, 0, 32'h3000,     32'h10,       32'h1234_5678, 0, 32'h0,       32'd1};
        vec[4]  = '{32'h0000_0020, 4'b1111, 32'hAABB_CCDD, 32'h0000_3004, 32'h0,        1, 32'h3004,     32'h20,       32'hAABB_CCDD, 0, 32'h0,       32'd2};
        vec[5]  = '{32'h0000_0022, 4'b0100, 32'h00EE_0000, 32'h0000_3008, 32'hAABB_CCDD, 1, 32'h3008,    32'h20,       32'hAAEE_CCDD, 0, 32'h0,       32'd3};
        vec[6]  = '{32'h0000_0020, 4'b0000, 32'h0,         32'h0,        32'hAAEE_CCDD, 0, 32'h3008,     32'h20,       32'hAAEE_CCDD, 0, 32'h0,       32'd3};
        vec[7]  = '{32'h0000_002E, 4'b1100, 32'hBEEF_0000, 32'h0000_300C, 32'h0,        1, 32'h300C,     32'h2C,       32'hBEEF_0000, 0, 32'h0,       32'd4};
        vec[8]  = '{32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 32'h0000_3010, 32'h0,        0, 32'h300C,     32'h2C,       32'hBEEF_0000, 1, 32'h3000,    32'd4};
        vec[9]  = '{32'h0000_4000, 4'b0000, 32'h0,         32'h0,        32'h0,         0, 32'h300C,     32'h2C,       32'hBEEF_0000, 1, 32'h3000,    32'd4};
        vec[10] = '{32'h0000_002C, 4'b0000, 32'h0,         32'h0,        32'hBEEF_0000, 0, 32'h300C,     32'h2C,       32'hBEEF_0000, 1, 32'h3000,    32'd4};
        vec[11] = '{32'h0000_2FFC, 4'b1111, 32'h55AA_55AA, 32'h0000_3014, 32'h0,        1, 32'h3014,     32'h2FFC,     32'h55AA_55AA, 1, 32'h3000,    32'd5};
        vec[12] = '{32'h0000_2FFF, 4'b0000, 32'h0,         32'h0,        32'h55AA_55AA, 0, 32'h3014,     32'h2FFC,     32'h55AA_55AA, 1, 32'h3000,    32'd5};

        drive(32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        model_reset();
        chk("reset.log_valid", 32'(s_lv), 32'd0);
        chk("reset.fault", 32'(s_fault), 32'd0);
        chk("reset.store_count", s_cnt, 32'd0);

        for (int i = 0; i < 13; i++) begin
            drive(vec[i].addr, vec[i].be, vec[i].wdata, vec[i].pc, 1'b0);
            chk($sformatf("vec%0d.rdata", i),       s_rdata,      vec[i].exp_rdata);
            chk($sformatf("vec%0d.log_valid", i),   32'(s_lv),    32'(vec[i].exp_lv));
            chk($sformatf("vec%0d.log_pc", i),      s_pc,         vec[i].exp_pc);
            chk($sformatf("vec%0d.log_addr", i),    s_laddr,      vec[i].exp_laddr);
            chk($sformatf("vec%0d.log_data", i),    s_ldata,      vec[i].exp_ldata);
            chk($sformatf("vec%0d.fault", i),       32'(s_fault), 32'(vec[i].exp_fault));
            chk($sformatf("vec%0d.fault_addr", i),  s_faddr,      vec[i].exp_faddr);
            chk($sformatf("vec%0d.store_count", i), s_cnt,        vec[i].exp_cnt);
            model_update(vec[i].addr, vec[i].be, vec[i].wdata, vec[i].pc);
        end

        // Store issued in the reset cycle must be discarded, and the array cleared.
        drive(32'h0000_0040, 4'b1111, 32'hCAFE_F00D, 32'h0000_3100, 1'b1);
        model_reset();
        drive(32'h0000_0040, 4'b0000, 32'h0, 32'h0, 1'b0);
        chk("rst_store.rdata", s_rdata, 32'h0);
        chk("rst_store.log_valid", 32'(s_lv), 32'd0);
        chk("rst_store.store_count", s_cnt, 32'd0);
        chk("rst_store.fault", 32'(s_fault), 32'd0);
        drive(32'h0000_0010, 4'b0000, 32'h0, 32'h0, 1'b0);
        chk("rst_clear.rdata", s_rdata, 32'h0);

        // Store pending in the buffer when reset arrives must not reach the array.
        drive(32'h0000_0050, 4'b1111, 32'h1111_2222, 32'h0000_3200, 1'b0);
        drive(32'h0000_0000, 4'b0000, 32'h0, 32'h0, 1'b1);
        model_reset();
        drive(32'h0000_0050, 4'b0000, 32'h0, 32'h0, 1'b0);
        chk("rst_pending.rdata", s_rdata, 32'h0);
        chk("rst_pending.store_count", s_cnt, 32'd0);

        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 16)      a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            else if (r < 18) a = (32'(3070 + $urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
            else             a = $urandom() | 32'h0000_C000;
            be = 4'($urandom_range(0, 15));
            wd = $urandom();
            pc = $urandom();
            exp_r = m_word(a);
            if ($urandom_range(0, 99) == 0) begin
                drive(a, be, wd, pc, 1'b1);
                chk("rnd.rdata", s_rdata, exp_r);
                model_reset();
                chk_regs_vs_model("rnd_reset");
            end else begin
                drive(a, be, wd, pc, 1'b0);
                chk("rnd.rdata", s_rdata, exp_r);
                model_update(a, be, wd, pc);
                chk_regs_vs_model("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
